mse_frame_tx: RTL
=================

// Module: mse_frame_tx
// PURPOSE
// Serialises each 64-bit MSE result from the error collector into a framed byte stream.
// Frame = header, 8 data bytes MSB-first, XOR checksum.
// Drives the UART transmitter byte interface directly, replacing ad-hoc result upload in the control unit.
// Holds one pending result while a frame is in flight; counts results dropped beyond that.
// PARAMETERS
// HDR_BYTE   8'hA5  first byte of every frame
// NUM_BYTES  8      data bytes per frame (data_in width = 8*NUM_BYTES)
// GAP_CYC    2      idle cycles enforced between consecutive byte pulses (0 allowed)
// PORTS
// clk         in   1   system clock
// rst         in   1   synchronous reset, active-high
// mse_valid   in   1   one-cycle strobe, mse_data valid
// mse_data    in   64  result to transmit
// tx_busy     in   1   UART transmitter busy; must rise the cycle after com_txvalid
// com_txvalid out  1   one-cycle byte strobe to transmitter
// com_txdata  out  8   byte to transmit, valid with com_txvalid
// frame_busy  out  1   high from frame start until the last byte completes
// frame_done  out  1   one-cycle pulse when the checksum byte completes (tx_busy fell)
// drop_cnt    out  8   results discarded since reset, saturates at 255
// BEHAVIOUR
// - Reset: com_txvalid=0, com_txdata=0, frame_busy=0, frame_done=0, drop_cnt=0; pending slot empty; FSM=IDLE.
// - Reset mid-frame aborts immediately. No further com_txvalid until a new mse_valid.
// - FSM states: IDLE, SEND, WAIT_HI, WAIT_LO, GAP. Byte index idx runs 0..NUM_BYTES+1.
//   idx 0 = header, idx 1..NUM_BYTES = data bytes MSB-first, idx NUM_BYTES+1 = checksum.
// - IDLE -> SEND when mse_valid=1 (or pending slot full).
//   Latch the data into the shift register; idx=0; csum=0; frame_busy=1 from the next cycle.
// - SEND: when tx_busy=0, pulse com_txvalid for 1 cycle with byte[idx], then go to WAIT_HI.
//   csum ^= byte for data bytes only.
// - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
//   If tx_busy is still 0 after 4 cycles, re-enter SEND and resend the same byte (lost-strobe recovery).
// - WAIT_LO: wait for tx_busy=0.
//   If idx = NUM_BYTES+1: pulse frame_done.
//     With pending empty: go to IDLE and drop frame_busy the same cycle as frame_done.
//     With pending full: load the pending result, restart at idx 0, keep frame_busy=1, go to GAP.
//   Otherwise: idx++ and go to GAP (or straight to SEND if GAP_CYC=0).
// - GAP: count GAP_CYC cycles, then go to SEND. The gap also applies between back-to-back frames.
// - Latency: mse_valid at cycle T with tx_busy=0 gives the header strobe at T+2.
// - Pending slot, 1 deep:
//   - mse_valid while frame_busy and slot empty: capture the result.
//   - mse_valid while slot full: discard the new result; drop_cnt++ (saturating). The pending entry is kept.
//   - mse_valid in the same cycle as the frame-end transition: captured into the slot, never dropped.
// - Checksum = XOR of the NUM_BYTES data bytes; the header is excluded.
// - com_txdata holds its value between strobes; only sampled when com_txvalid=1.
// TESTING
// 1. mse_data=64'h0123456789ABCDEF, transmitter model busy 10 cyc/byte
//    -> bytes A5 01 23 45 67 89 AB CD EF 00, one frame_done.
// 2. mse_data=64'hFF00000000000000 -> checksum byte FF; header strobe 2 cycles after mse_valid.
// 3. Three mse_valid during one frame: 64'h1, 64'h2, 64'h3
//    -> frames for 1 and 2 only, drop_cnt=1, GAP_CYC idle cycles between the frames.
// 4. Transmitter ignores the 3rd strobe (tx_busy stays 0)
//    -> same byte re-strobed after 4 cycles; frame still completes correctly.
// 5. rst asserted after the 4th byte -> all outputs zero next cycle;
//    new mse_valid then yields a full fresh frame starting with A5.
// 6. 300 results offered during a long stalled frame -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/mse_frame_tx.sv
// mse_frame_tx
// Turns each 64-bit MSE result into a framed byte stream for the UART
// transmitter: header byte, NUM_BYTES data bytes MSB-first, then an XOR
// checksum of the data bytes. One further result can wait in a pending slot
// while a frame is in flight; anything beyond that is counted as dropped.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   mse_valid   one-cycle strobe, mse_data valid
//   mse_data    result to transmit (8*NUM_BYTES bits)
//   tx_busy     transmitter busy, rises the cycle after com_txvalid
//   com_txvalid one-cycle byte strobe to the transmitter
//   com_txdata  byte to transmit, held between strobes
//   frame_busy  high from frame start until the last byte completes
//   frame_done  one-cycle pulse when the checksum byte completes
//   drop_cnt    results discarded since reset, saturating at 255

module mse_frame_tx #(
  parameter logic [7:0] HDR_BYTE  = 8'hA5,
  parameter int         NUM_BYTES = 8,
  parameter int         GAP_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mse_valid,
  input  logic [8*NUM_BYTES-1:0] mse_data,
  input  logic                   tx_busy,
  output logic                   com_txvalid,
  output logic [7:0]             com_txdata,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic [7:0]             drop_cnt
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int IW = $clog2(NUM_BYTES + 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BYTES + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  // WAIT_HI gives up after this many cycles without tx_busy and resends
  localparam logic [1:0] RETRY_LAST = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    GAP
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [DW-1:0] shreg, shreg_d;
  logic [7:0]    csum, csum_d;
  logic          pend_valid, pend_valid_d;
  logic [DW-1:0] pend_data, pend_data_d;
  logic [1:0]    wait_cnt, wait_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          txvalid_d;
  logic [7:0]    txdata_d;
  logic          done_d;
  logic [7:0]    drop_d;
  logic [7:0]    cur_byte;
  logic          mse_taken;

  // All state and registered outputs; reset aborts any frame and empties the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      shreg       <= '0;
      csum        <= '0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      com_txvalid <= 1'b0;
      com_txdata  <= '0;
      frame_done  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      shreg       <= shreg_d;
      csum        <= csum_d;
      pend_valid  <= pend_valid_d;
      pend_data   <= pend_data_d;
      wait_cnt    <= wait_cnt_d;
      gap_cnt     <= gap_cnt_d;
      com_txvalid <= txvalid_d;
      com_txdata  <= txdata_d;
      frame_done  <= done_d;
      drop_cnt    <= drop_d;
    end
  end

  assign frame_busy = (state != IDLE);

  // Data bytes always come from the top of the shift register, which is
  // shifted only once a data byte has been accepted by the transmitter
  always_comb begin
    cur_byte = shreg[DW-1 -: 8];
    if (idx == '0) begin
      cur_byte = HDR_BYTE;
    end else if (idx == IDX_LAST) begin
      cur_byte = csum;
    end
  end

  // Next-state, datapath and pending-slot logic
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    shreg_d      = shreg;
    csum_d       = csum;
    pend_valid_d = pend_valid;
    pend_data_d  = pend_data;
    wait_cnt_d   = wait_cnt;
    gap_cnt_d    = gap_cnt;
    txvalid_d    = 1'b0;
    txdata_d     = com_txdata;
    done_d       = 1'b0;
    drop_d       = drop_cnt;
    mse_taken    = 1'b0;

    case (state)
      IDLE: begin
        if (pend_valid) begin
          shreg_d      = pend_data;
          pend_valid_d = 1'b0;
          idx_d        = '0;
          csum_d       = '0;
          state_d      = SEND;
        end else if (mse_valid) begin
          shreg_d   = mse_data;
          mse_taken = 1'b1;
          idx_d     = '0;
          csum_d    = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          txvalid_d  = 1'b1;
          txdata_d   = cur_byte;
          wait_cnt_d = '0;
          state_d    = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (wait_cnt == RETRY_LAST) begin
          state_d = SEND;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end

      // The checksum is accumulated here rather than at the strobe so that a
      // resent byte after a lost strobe is not folded in twice
      WAIT_LO: begin
        if (!tx_busy) begin
          gap_cnt_d = '0;
          if (idx == IDX_LAST) begin
            done_d = 1'b1;
            idx_d  = '0;
            csum_d = '0;
            if (pend_valid) begin
              shreg_d      = pend_data;
              pend_valid_d = 1'b0;
              if (GAP_CYC == 0) state_d = SEND;
              else              state_d = GAP;
            end else if (mse_valid) begin
              shreg_d   = mse_data;
              mse_taken = 1'b1;
              if (GAP_CYC == 0) state_d = SEND;
              else              state_d = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (idx != '0) begin
              csum_d  = csum ^ shreg[DW-1 -: 8];
              shreg_d = shreg << 8;
            end
            idx_d = idx + 1'b1;
            if (GAP_CYC == 0) state_d = SEND;
            else              state_d = GAP;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A result not consumed directly goes to the slot if the slot is (or has
    // just become) free; otherwise it is lost and counted
    if (mse_valid && !mse_taken) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_data_d  = mse_data;
      end else if (drop_cnt != 8'hFF) begin
        drop_d = drop_cnt + 1'b1;
      end
    end
  end

endmodule
